// File: rtl/ttfs_charger_lanes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttfs_charge_pkg
//  Purpose  : Shared types and the saturating-add helper for the multi-lane
//             TTFS charge unit.
//  Revision : 1.0 - initial release
// ============================================================================
package ttfs_charge_pkg;

  typedef enum logic [0:0] {
    RAMP   = 1'b0,
    DIRECT = 1'b1
  } charge_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } charger_state_e;

  // Result of a saturating add: clamped value plus a flag for "clamped".
  typedef struct packed {
    logic              sat;
    logic signed [31:0] value;
  } sat_res_t;

  // Adds two sign-extended operands and clamps to the signed range of a
  // destination that is 'width' bits wide. The 33-bit sum cannot overflow.
  function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input int                 width);
    logic signed [32:0] sum;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    sat_res_t           res;
    sum       = 33'(a) + 33'(b);
    max_v     = (33'sd1 <<< (width - 1)) - 33'sd1;
    min_v     = -(33'sd1 <<< (width - 1));
    res.sat   = 1'b0;
    res.value = sum[31:0];
    if (sum > max_v) begin
      res.sat   = 1'b1;
      res.value = max_v[31:0];
    end else if (sum < min_v) begin
      res.sat   = 1'b1;
      res.value = min_v[31:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttfs_charger_lanes_if.sv
`default_nettype none
// ============================================================================
//  Module   : ttfs_charger_lanes_if
//  Purpose  : Synapse-word stream (valid/ready, packed weights, lane mask)
//             into the multi-lane TTFS charge unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface ttfs_charger_lanes_if #(
  parameter int LANES = 8
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      synapse_data_i;
  logic [LANES-1:0] lane_mask_i;

  modport master (
    output in_valid_i,
    output synapse_data_i,
    output lane_mask_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i,
    input  synapse_data_i,
    input  lane_mask_i,
    output in_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/ttfs_charger_lanes_lane.sv
`default_nettype none
// ============================================================================
//  Module   : charger_lane
//  Purpose  : One lane of the TTFS charge unit: slope, charge and sticky
//             saturation flag, with RAMP/DIRECT update and clear.
//  Revision : 1.0 - initial release
// ============================================================================
module charger_lane
  import ttfs_charge_pkg::*;
#(
  parameter int W_W     = 4,
  parameter int SLOPE_W = 12,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_W-1:0]   weight_i,
  input  logic             add_en_i,
  input  logic             tick_en_i,
  input  logic             clear_i,
  input  logic             sat_set_i,
  input  charge_mode_e     mode_i,
  output logic [ACC_W-1:0] charge_o,
  output logic             sat_o
);

  logic [SLOPE_W-1:0] slope_q, slope_d;
  logic [ACC_W-1:0]   charge_q, charge_d;
  logic               sat_q, sat_d;

  logic signed [31:0] w_ext, s_ext, c_ext;
  sat_res_t           slope_add, charge_tick, charge_word;
  logic               unused_bits;

  assign w_ext = {{(32-W_W){weight_i[W_W-1]}}, weight_i};
  assign s_ext = {{(32-SLOPE_W){slope_q[SLOPE_W-1]}}, slope_q};
  assign c_ext = {{(32-ACC_W){charge_q[ACC_W-1]}}, charge_q};

  // The tick always integrates the slope as it stood before this update.
  assign slope_add   = sat_add(s_ext, w_ext, SLOPE_W);
  assign charge_tick = sat_add(c_ext, s_ext, ACC_W);
  assign charge_word = sat_add(c_ext, w_ext, ACC_W);

  // Clamped results always fit the destination; the upper bits are copies.
  assign unused_bits = ^{slope_add.value[31:SLOPE_W],
                         charge_tick.value[31:ACC_W],
                         charge_word.value[31:ACC_W]};

  // Next-state: clear wins, otherwise RAMP or DIRECT accumulation.
  always_comb begin
    slope_d  = slope_q;
    charge_d = charge_q;
    sat_d    = sat_q | sat_set_i;
    if (clear_i) begin
      slope_d  = '0;
      charge_d = '0;
    end else if (mode_i == RAMP) begin
      if (add_en_i) begin
        slope_d = slope_add.value[SLOPE_W-1:0];
        sat_d   = sat_d | slope_add.sat;
      end
      if (tick_en_i) begin
        charge_d = charge_tick.value[ACC_W-1:0];
        sat_d    = sat_d | charge_tick.sat;
      end
    end else if (add_en_i) begin
      charge_d = charge_word.value[ACC_W-1:0];
      sat_d    = sat_d | charge_word.sat;
    end
  end

  // Lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slope_q  <= '0;
      charge_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      slope_q  <= slope_d;
      charge_q <= charge_d;
      sat_q    <= sat_d;
    end
  end

  assign charge_o = charge_q;
  assign sat_o    = sat_q;

endmodule
`default_nettype wire

// File: rtl/ttfs_charger_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : ttfs_charger_lanes
//  Purpose  : Multi-lane TTFS charge unit. Unpacks each 32-bit synapse word
//             into LANES signed weights; RAMP integrates slopes on ticks,
//             DIRECT adds weights straight into the charges.
//             LANES*W_W must equal 32 and ACC_W >= SLOPE_W.
//  Revision : 1.0 - initial release
// ============================================================================
module ttfs_charger_lanes
  import ttfs_charge_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int W_W     = 4,
  parameter int SLOPE_W = 12,
  parameter int ACC_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_i,
  ttfs_charger_lanes_if.slave    syn_if,
  input  logic                   tick_i,
  input  logic [LANES-1:0]       lane_clear_i,
  output logic [LANES*ACC_W-1:0] charge_o,
  output logic                   charge_valid_o,
  output logic [LANES-1:0]       sat_flags_o,
  output logic                   idle_o
);

  charger_state_e   state_q, state_d;
  charge_mode_e     mode_q, mode_d;
  logic             tick_pend_q, tick_pend_d;
  logic             tick_run_q, tick_run_d;
  logic             word_vld_q, word_vld_d;
  logic [31:0]      weights_q, weights_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] blocked_q, blocked_d;

  logic in_accum, accept, tick_req, overrun;

  assign in_accum          = (state_q == ACCUM);
  assign syn_if.in_ready_o = !in_accum;
  assign accept            = syn_if.in_valid_i & !in_accum;
  assign charge_valid_o    = (state_q == PUBLISH);
  assign idle_o            = (state_q == IDLE);

  // Next-state: capture a word and/or tick into a job, run it for one ACCUM
  // cycle, publish. Ticks seen during ACCUM wait in a 1-deep pending flag;
  // a clear outside ACCUM keeps that lane at zero through the next update.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tick_pend_d = tick_pend_q;
    tick_run_d  = tick_run_q;
    word_vld_d  = word_vld_q;
    weights_d   = weights_q;
    mask_d      = mask_q;
    blocked_d   = blocked_q;
    tick_req    = 1'b0;
    overrun     = 1'b0;
    case (state_q)
      IDLE, PUBLISH: begin
        tick_req  = tick_i | tick_pend_q;
        overrun   = tick_i & tick_pend_q;
        blocked_d = blocked_q | lane_clear_i;
        if (state_q == IDLE) begin
          mode_d = charge_mode_e'(mode_i);
        end
        if (accept | tick_req) begin
          state_d     = ACCUM;
          word_vld_d  = accept;
          weights_d   = syn_if.synapse_data_i;
          mask_d      = syn_if.lane_mask_i;
          tick_run_d  = tick_req;
          tick_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        state_d   = PUBLISH;
        blocked_d = '0;
        if (tick_i) begin
          tick_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= RAMP;
      tick_pend_q <= 1'b0;
      tick_run_q  <= 1'b0;
      word_vld_q  <= 1'b0;
      weights_q   <= '0;
      mask_q      <= '0;
      blocked_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tick_pend_q <= tick_pend_d;
      tick_run_q  <= tick_run_d;
      word_vld_q  <= word_vld_d;
      weights_q   <= weights_d;
      mask_q      <= mask_d;
      blocked_q   <= blocked_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lanes
    charger_lane #(
      .W_W     (W_W),
      .SLOPE_W (SLOPE_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .weight_i  (weights_q[l*W_W +: W_W]),
      .add_en_i  (in_accum & word_vld_q & mask_q[l]),
      .tick_en_i (in_accum & tick_run_q),
      .clear_i   (lane_clear_i[l] | (in_accum & blocked_q[l])),
      .sat_set_i (overrun),
      .mode_i    (mode_q),
      .charge_o  (charge_o[l*ACC_W +: ACC_W]),
      .sat_o     (sat_flags_o[l])
    );
  end

endmodule
`default_nettype wire
